load_store_unit: RTL

Initiator-side memory access unit between the core's execute stage and `data_memory`. It accepts one load or store request at a time using a valid/ready handshake and turns RV32I byte, halfword and word accesses into word-only memory transactions. Sub-word stores use a read-modify-write sequence. Loads are returned sign- or zero-extended, with a one-cycle response strobe.

---
 rtl/load_store_unit_if.sv | 32 +++
 rtl/load_store_unit.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/load_store_unit_if.sv
// Request/response and memory-side bus of the load/store unit.
// master: the LSU itself (it starts the memory transactions).
// slave : the surrounding core and data memory.
interface load_store_unit_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  resp_valid;
  logic [31:0]           resp_rdata;
  logic                  resp_error;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic                  mem_write_enable;
  logic [31:0]           mem_write_data;
  logic [31:0]           mem_read_data;

  modport master (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_read_data,
    output req_ready, resp_valid, resp_rdata, resp_error,
           mem_address, mem_write_enable, mem_write_data
  );

  modport slave (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_read_data,
    input  req_ready, resp_valid, resp_rdata, resp_error,
           mem_address, mem_write_enable, mem_write_data
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: byte/half/word accesses mapped onto a word-only
// memory, sub-word stores done as read-modify-write.
// Optional feature macro: LSU_ALIGN_CHECK_EN (alignment / funct3 errors).
// Outputs are registered as each state completes, so a response strobe
// appears in the cycle after the FSM leaves RESP.
module load_store_unit #(
  parameter int ADDR_WIDTH = 32
) (
  input logic               clk,
  input logic               reset,
  load_store_unit_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RMW_READ, S_WRITE, S_RESP
  } state_t;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  state_t                state_q;
  logic [1:0]            size_q;
  logic                  unsigned_q;
  logic [1:0]            off_q;
  logic [31:0]           wdata_q;
  logic                  err_q;
  logic [31:0]           old_q;
  logic [31:0]           rdata_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic                  mem_we_q;
  logic [31:0]           mem_wdata_q;
  logic                  resp_valid_q;
  logic [31:0]           resp_rdata_q;
  logic                  resp_error_q;

  logic                  req_legal;
  logic [1:0]            req_size;
  logic                  req_err_d;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [31:0]           load_d;
  logic [31:0]           merge_d;

  // Decode the incoming request: access size and error condition.
  // Illegal funct3 falls back to a word access when no checking is built in.
  always_comb begin
    req_legal = bus.req_write ? (bus.req_funct3 <= 3'b010)
                              : (bus.req_funct3 != 3'b011 && bus.req_funct3[2:1] != 2'b11);
    req_size  = req_legal ? bus.req_funct3[1:0] : SZ_W;
`ifdef LSU_ALIGN_CHECK_EN
    req_err_d = !req_legal
             || (req_size == SZ_H && bus.req_addr[0])
             || (req_size == SZ_W && bus.req_addr[1:0] != 2'b00);
`else
    req_err_d = 1'b0;
`endif
  end

  // Lane extraction for loads and lane merge for sub-word stores.
  always_comb begin
    ld_byte = bus.mem_read_data[{off_q, 3'b000} +: 8];
    ld_half = bus.mem_read_data[{off_q[1], 4'b0000} +: 16];
    case (size_q)
      SZ_B:    load_d = unsigned_q ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      SZ_H:    load_d = unsigned_q ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: load_d = bus.mem_read_data;
    endcase
    merge_d = old_q;
    case (size_q)
      SZ_B:    merge_d[{off_q, 3'b000} +: 8]    = wdata_q[7:0];
      SZ_H:    merge_d[{off_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merge_d = wdata_q;
    endcase
  end

  // Main FSM with registered outputs; reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      size_q       <= SZ_W;
      unsigned_q   <= 1'b0;
      off_q        <= 2'b00;
      wdata_q      <= '0;
      err_q        <= 1'b0;
      old_q        <= '0;
      rdata_q      <= '0;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_error_q <= 1'b0;
    end else begin
      mem_we_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_error_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            mem_addr_q <= {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
            off_q      <= bus.req_addr[1:0];
            size_q     <= req_size;
            unsigned_q <= bus.req_funct3[2];
            wdata_q    <= bus.req_wdata;
            err_q      <= req_err_d;
            rdata_q    <= '0;
            if (req_err_d)              state_q <= S_RESP;
            else if (!bus.req_write)    state_q <= S_LOAD;
            else if (req_size == SZ_W)  state_q <= S_WRITE;
            else                        state_q <= S_RMW_READ;
          end
        end
        S_LOAD: begin
          rdata_q <= load_d;
          state_q <= S_RESP;
        end
        S_RMW_READ: begin
          old_q   <= bus.mem_read_data;
          state_q <= S_WRITE;
        end
        S_WRITE: begin
          mem_we_q    <= 1'b1;
          mem_wdata_q <= merge_d;
          state_q     <= S_RESP;
        end
        S_RESP: begin
          resp_valid_q <= 1'b1;
          resp_rdata_q <= rdata_q;
          resp_error_q <= err_q;
          state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready        = (state_q == S_IDLE) && !reset;
  assign bus.mem_write_enable = mem_we_q && !reset;
  assign bus.mem_address      = mem_addr_q;
  assign bus.mem_write_data   = mem_wdata_q;
  assign bus.resp_valid       = resp_valid_q;
  assign bus.resp_rdata       = resp_rdata_q;
  assign bus.resp_error       = resp_error_q;

endmodule
